mix_columns_serial: RTL and testbench
=====================================

Name: mix_columns_serial

Overview:
- AES-128 MixColumns stage, directly downstream of the SubBytes/ShiftRows path.
- Captures a 128-bit state and multiplies each 4-byte column by the fixed GF(2^8) matrix {02 03 01 01}, COLS_PER_CYCLE columns per clock.
- Uses the same level-held strt/finish handshake as the neighbouring round stages.
- Result feeds AddRoundKey.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4; compute cycles N = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- strt  input  1  level request; high = run/hold, low = clear to idle
- data_in  input  128  state from upstream stage; byte k = bits [127-8k -: 8]; column c = bytes 4c..4c+3, row r = byte 4c+r
- finish_mix  output  1  high while result valid and strt still high
- mix_out  output  128  MixColumns result, same byte ordering as data_in

Behaviour:
- Reset (rst_n=0, async): state=IDLE, col counter=0, capture reg=0, mix_out=0, finish_mix=0.
- States: IDLE, RUN, DONE; 2-bit column counter.
- IDLE:
  - strt=0: stay; finish_mix=0; mix_out holds.
  - strt=1 at edge E0: latch data_in, col=0, -> RUN, mix_out=0.
  - data_in is sampled only at E0; later changes are ignored.
- RUN, each edge:
  - Compute columns col .. col+COLS_PER_CYCLE-1 from the capture reg; write to the matching mix_out bytes.
  - col += COLS_PER_CYCLE, wrapping mod 4.
  - On the edge processing column 3 -> DONE and finish_mix=1 on the same edge.
- Latency: finish_mix rises at edge E0+N (N=4 at default), i.e. 5 edges including the capture edge. mix_out is fully valid whenever finish_mix=1.
- DONE:
  - strt=1: hold state, finish_mix=1, mix_out stable.
  - strt=0: -> IDLE, finish_mix=0, mix_out retains result.
- Abort: strt=0 during RUN -> IDLE next edge, mix_out=0, finish_mix=0, col=0. Partial results are never exposed.
- Re-run needs strt to go low for at least one edge; DONE never restarts on its own.
- Per-column arithmetic, bytes a0..a3:
  - o0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - o1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - o2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - o3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits; 3x = xtime(x) ^ x.
- Async reset mid-RUN or in DONE: immediate return to reset values; no output glitch beyond the reset assertion.
- Illegal COLS_PER_CYCLE (not 1/2/4): elaboration-time error.

Optional Feature:
- Macro MIX_COLUMNS_INV_EN.
- Defined:
  - Adds input port inv (1 bit), sampled with data_in at E0.
  - inv=1 selects InvMixColumns, matrix {0e 0b 0d 09}, built from chained xtime: 9x=8x^x, 0b=8x^2x^x, 0d=8x^4x^x, 0e=8x^4x^2x.
  - Latency and handshake unchanged.
- Undefined: no inv port; forward transform only; no inverse logic synthesised.

Test Plan:
- Reset/idle: rst_n=0 then 1, strt=0 -> mix_out=0, finish_mix=0; mix_out holds across idle cycles.
- FIPS-197 round 1: data_in=d4bf5d30e0b452aeb84111f11e2798e5, strt held high -> finish_mix rises exactly at edge E0+4; mix_out=046681e5e0cb199a48f8d37a2806264c; holds while strt=1.
- Known columns:
  - data_in=db135345_f20a225c_01010101_2d26314c -> mix_out=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - Repeat with COLS_PER_CYCLE=2 (finish at E0+2) and 4 (finish at E0+1).
- Abort: strt dropped after 2 RUN edges -> IDLE, mix_out=0, finish_mix=0. Re-raise strt with the FIPS vector -> correct result after a full 4 cycles.
- Async reset in DONE: rst_n pulsed low mid-cycle -> finish_mix and mix_out go to 0 immediately, without waiting for a clock edge.
- MIX_COLUMNS_INV_EN: inv=1, data_in=046681e5e0cb199a48f8d37a2806264c -> mix_out=d4bf5d30e0b452aeb84111f11e2798e5 after the same latency.

Source files
------------

// File: rtl/mix_columns_serial.sv
// mix_columns_serial: AES MixColumns stage that processes COLS_PER_CYCLE state
// columns per clock under a level-held strt/finish_mix handshake.
// The optional inverse transform (InvMixColumns, selected by port inv) is
// built only when the macro MIX_COLUMNS_INV_EN is defined.
module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         strt,
    input  logic [127:0] data_in,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         inv,
`endif
    output logic         finish_mix,
    output logic [127:0] mix_out
);

    // Only 1, 2 or 4 columns per clock divide the 4-column state evenly.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Column advance per clock and the first column of the final batch.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'((4 - COLS_PER_CYCLE) % 4);

    state_t            state_reg, state_next;
    logic [1:0]        col_reg;
    logic [3:0][31:0]  cap_reg;   // column c lives at index 3-c
    logic [3:0][31:0]  mix_reg;
    logic [3:0][31:0]  run_cols;
    logic [1:0]        lane_col [COLS_PER_CYCLE];
    logic [31:0]       lane_res [COLS_PER_CYCLE];
    logic              last_step;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic inv_reg;

    // Multiply by {09,0b,0d,0e} via chained doubling; returns {9x,bx,dx,ex}.
    function automatic logic [31:0] inv_mults(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return {x8 ^ x, x8 ^ x2 ^ x, x8 ^ x4 ^ x, x8 ^ x4 ^ x2};
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        for (int i = 0; i < 4; i++) begin
            {m9[i], mb[i], md[i], me[i]} = inv_mults(a[31-8*i -: 8]);
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    // One arithmetic lane per column handled in a clock.
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
        assign lane_col[gi] = col_reg + 2'(gi);
`ifdef MIX_COLUMNS_INV_EN
        assign lane_res[gi] = inv_reg ? inv_col(cap_reg[2'd3 - lane_col[gi]])
                                      : fwd_col(cap_reg[2'd3 - lane_col[gi]]);
`else
        assign lane_res[gi] = fwd_col(cap_reg[2'd3 - lane_col[gi]]);
`endif
    end

    // Merge this clock's lane results into the current output columns.
    always_comb begin
        run_cols = mix_reg;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            run_cols[2'd3 - lane_col[k]] = lane_res[k];
        end
    end

    assign last_step  = (col_reg == LAST);
    assign finish_mix = (state_reg == DONE);
    assign mix_out    = mix_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: strt low always returns to IDLE; DONE holds while strt high.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (strt) state_next = RUN;
            RUN:     if (!strt) state_next = IDLE;
                     else if (last_step) state_next = DONE;
            DONE:    if (!strt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on start, fill columns while running, clear on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg <= 2'd0;
            cap_reg <= '0;
            mix_reg <= '0;
`ifdef MIX_COLUMNS_INV_EN
            inv_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (strt) begin
                    cap_reg <= data_in;
                    col_reg <= 2'd0;
                    mix_reg <= '0;
`ifdef MIX_COLUMNS_INV_EN
                    inv_reg <= inv;
`endif
                end
                RUN: if (!strt) begin
                    col_reg <= 2'd0;
                    mix_reg <= '0;
                end else begin
                    col_reg <= col_reg + STEP;
                    mix_reg <= run_cols;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Directed bench for mix_columns_serial at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_serial;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] KC_IN    = 128'hdb135345f20a225c010101012d26314c;
    localparam logic [127:0] KC_OUT   = 128'h8e4da1bc9fdc589d010101014d7ebdf8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         strt;
    logic [127:0] data_in;
    logic         inv;
    logic         fin1, fin2, fin4;
    logic [127:0] mix1, mix2, mix4;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mix_columns_serial #(.COLS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .strt(strt), .data_in(data_in),
`ifdef MIX_COLUMNS_INV_EN
        .inv(inv),
`endif
        .finish_mix(fin1), .mix_out(mix1));

    mix_columns_serial #(.COLS_PER_CYCLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .strt(strt), .data_in(data_in),
`ifdef MIX_COLUMNS_INV_EN
        .inv(inv),
`endif
        .finish_mix(fin2), .mix_out(mix2));

    mix_columns_serial #(.COLS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .strt(strt), .data_in(data_in),
`ifdef MIX_COLUMNS_INV_EN
        .inv(inv),
`endif
        .finish_mix(fin4), .mix_out(mix4));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; strt = 1'b0; data_in = '0; inv = 1'b0;
        #12;
        check("rst_fin", 128'(fin1), 128'd0);
        check("rst_mix", mix1, 128'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_fin", 128'(fin1), 128'd0);
        check("idle_mix", mix1, 128'd0);
        $display("txn reset/idle done");

        // FIPS-197 round 1 column mix, strt held high
        data_in = FIPS_IN; strt = 1'b1;
        tick();                                  // E0
        check("fips_e0_fin", 128'(fin1), 128'd0);
        check("fips_e0_mix", mix1, 128'd0);
        data_in = {4{32'hffffffff}};             // must be ignored
        tick();                                  // E1
        check("fips_e1_fin1", 128'(fin1), 128'd0);
        check("fips_e1_fin2", 128'(fin2), 128'd0);
        check("fips_e1_fin4", 128'(fin4), 128'd1);
        check("fips_e1_mix4", mix4, FIPS_OUT);
        tick();                                  // E2
        check("fips_e2_fin1", 128'(fin1), 128'd0);
        check("fips_e2_fin2", 128'(fin2), 128'd1);
        check("fips_e2_mix2", mix2, FIPS_OUT);
        tick();                                  // E3
        check("fips_e3_fin1", 128'(fin1), 128'd0);
        tick();                                  // E4
        check("fips_e4_fin1", 128'(fin1), 128'd1);
        check("fips_e4_mix1", mix1, FIPS_OUT);
        tick(); tick();
        check("fips_hold_fin", 128'(fin1), 128'd1);
        check("fips_hold_mix", mix1, FIPS_OUT);
        strt = 1'b0;
        tick();
        check("fips_drop_fin", 128'(fin1), 128'd0);
        check("fips_drop_mix", mix1, FIPS_OUT);
        tick();
        check("fips_idle_mix", mix1, FIPS_OUT);
        $display("txn fips: mix1=%h", mix1);

        // Known-column vector at all three widths
        data_in = KC_IN; strt = 1'b1;
        tick();                                  // E0
        tick();                                  // E1
        check("kc_fin4", 128'(fin4), 128'd1);
        check("kc_mix4", mix4, KC_OUT);
        tick();                                  // E2
        check("kc_fin2", 128'(fin2), 128'd1);
        check("kc_mix2", mix2, KC_OUT);
        tick();                                  // E3
        check("kc_e3_fin1", 128'(fin1), 128'd0);
        tick();                                  // E4
        check("kc_fin1", 128'(fin1), 128'd1);
        check("kc_mix1", mix1, KC_OUT);
        strt = 1'b0;
        tick();
        $display("txn known-columns: mix1=%h", mix1);

        // Abort after two RUN edges, then a clean re-run
        data_in = KC_IN; strt = 1'b1;
        tick(); tick(); tick();                  // E0, E1, E2
        strt = 1'b0;
        tick();
        check("abort_fin", 128'(fin1), 128'd0);
        check("abort_mix", mix1, 128'd0);
        data_in = FIPS_IN; strt = 1'b1;
        tick();                                  // E0
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("rerun_e%0d_fin", i), 128'(fin1), 128'd0);
        end
        tick();                                  // E4
        check("rerun_fin", 128'(fin1), 128'd1);
        check("rerun_mix", mix1, FIPS_OUT);
        $display("txn abort/rerun: mix1=%h", mix1);

        // Asynchronous reset while in DONE, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_fin", 128'(fin1), 128'd0);
        check("areset_mix", mix1, 128'd0);
        check("areset_mix2", mix2, 128'd0);
        strt = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        $display("txn async reset done");

`ifdef MIX_COLUMNS_INV_EN
        // Inverse transform restores the FIPS input
        inv = 1'b1; data_in = FIPS_OUT; strt = 1'b1;
        tick();                                  // E0
        inv = 1'b0;
        tick(); tick(); tick();
        check("inv_e3_fin", 128'(fin1), 128'd0);
        tick();                                  // E4
        check("inv_fin", 128'(fin1), 128'd1);
        check("inv_mix", mix1, FIPS_IN);
        check("inv_mix4", mix4, FIPS_IN);
        strt = 1'b0;
        tick();
        $display("txn inverse: mix1=%h", mix1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
